npc_gen: RTL
============

Name: npc_gen

Overview:
Next-PC generator: the writer side of the PC register. Each cycle it computes the value and write enable presented to the PC register's input. It handles sequential fetch, branch/jump/eret/exception redirects and stalls. A redirect that arrives while the pipeline is stalled is held in a pending slot until the stall releases, so it is never lost.

Parameters:
RESET_PC, 32'h00400000, value driven on pc_next during reset; must equal the PC register's reset value
EXC_VECTOR, 32'h00400004, exception and misaligned-target redirect address
CNT_W, 16, width of the saturating redirect counter

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset
stall  input  1  pipeline stall; the PC register must not be written while high
pc_cur  input  32  current PC from the PC register output
exc_req  input  1  exception redirect to EXC_VECTOR
eret_req  input  1  return redirect to epc
epc  input  32  eret target
br_taken  input  1  taken branch
br_target  input  32  branch target
jmp_valid  input  1  jump
jmp_target  input  32  jump target
pc_next  output  32  value for the PC register input
pc_we  output  1  PC register write enable
flush_if  output  1  one-cycle flush of the IF/ID stage, registered
addr_err  output  1  one-cycle pulse: a misaligned target was replaced, registered
bad_addr  output  32  last misaligned target, registered
redirect_pending  output  1  high while in HOLD
redir_cnt  output  CNT_W  count of committed redirects, saturating

Behaviour:
- Reset is synchronous on the clk edge with rst=1. After reset:
  - state=RUN, pend_pc=0, pend_pri=0.
  - flush_if=0, addr_err=0, bad_addr=0, redir_cnt=0.
  - While rst=1: pc_we=0 and pc_next=RESET_PC, regardless of the other inputs.
- Request priority, highest first: exc(3) > eret(2) > br(1) > jmp(0). When several requests arrive together, only the winner is used.
- Alignment check:
  - An eret, branch or jump target with bits[1:0]!=0 is replaced by EXC_VECTOR and treated as priority 3.
  - Registered effects on the cycle the request is accepted (committed or captured): addr_err=1 and bad_addr=original target.
  - Exception targets are never checked.
- pc_next and pc_we are combinational from the current state and inputs. Zero latency: the PC register takes the new value on the next edge.
- State RUN, stall=0:
  - With a request: pc_next=target, pc_we=1. Next cycle flush_if=1 and redir_cnt increments.
  - Without a request: pc_next=pc_cur+4, pc_we=1. The sum is 32-bit and wraps, so 0xFFFFFFFC becomes 0x00000000.
- State RUN, stall=1:
  - pc_we=0, pc_next=pc_cur+4 (don't-care value).
  - With a request: pend_pc=target, pend_pri=its priority, state becomes HOLD.
- State HOLD, stall=1:
  - pc_we=0, redirect_pending=1.
  - A new request with priority >= pend_pri overwrites pend_pc and pend_pri. A strictly lower-priority request is dropped.
- State HOLD, stall=0:
  - pc_we=1. pc_next=pend_pc, unless a same-cycle request has priority >= pend_pri, in which case that request's target is used.
  - State returns to RUN. Next cycle flush_if=1 and redir_cnt increments by exactly 1.
- flush_if and addr_err are single-cycle pulses. Back-to-back commits produce back-to-back pulses.
- redir_cnt saturates at all-ones and does not wrap.
- rst asserted in HOLD discards the pending redirect. The next RUN cycle after reset fetches sequentially.

Test Plan:
- Reset then run 4 cycles, stall=0, no requests -> pc_next sequence 0x00400000 (in reset), 0x00400004, 0x00400008, 0x0040000C (with pc_cur tracked); pc_we=1; flush_if=0 throughout.
- RUN, pc_cur=0x00400010, br_taken=1, br_target=0x00400100 -> same cycle pc_next=0x00400100, pc_we=1; next cycle flush_if=1, redir_cnt=1.
- stall=1 for 3 cycles with jmp 0x00400200 in cycle 1 and br 0x00400300 in cycle 2, then stall=0 -> redirect_pending=1 during the stall, pc_we=0; on release pc_next=0x00400300 and redir_cnt rises by exactly 1.
- HOLD with a pending branch, exc_req=1 arrives in the release cycle -> pc_next=0x00400004; a later jmp with the stall high is dropped if an exc is already pending.
- jmp_target=0x00400202 -> pc_next=0x00400004; next cycle addr_err=1 and bad_addr=0x00400202.
- pc_cur=0xFFFFFFFC with no request -> pc_next=0x00000000; drive 65536+ redirects -> redir_cnt holds at 0xFFFF; rst in HOLD -> redirect_pending=0 and no redirect after reset.

Source files
------------

// File: rtl/npc_gen.sv
// Next-PC generator: drives the PC register input and write enable. It handles sequential
// fetch, prioritised redirects, stalls, and a pending slot for redirects seen during a stall.
module npc_gen #(
   parameter logic [31:0] RESET_PC   = 32'h00400000,
   parameter logic [31:0] EXC_VECTOR = 32'h00400004,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [31:0]      pc_cur,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [31:0]      epc,
   input  logic             br_taken,
   input  logic [31:0]      br_target,
   input  logic             jmp_valid,
   input  logic [31:0]      jmp_target,
   output logic [31:0]      pc_next,
   output logic             pc_we,
   output logic             flush_if,
   output logic             addr_err,
   output logic [31:0]      bad_addr,
   output logic             redirect_pending,
   output logic [CNT_W-1:0] redir_cnt
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic [1:0]  pend_pri_q, pend_pri_d;

   logic        req_any;
   logic        req_chk;
   logic        misalign;
   logic [31:0] raw_tgt;
   logic [31:0] req_tgt;
   logic [1:0]  raw_pri;
   logic [1:0]  req_pri;
   logic        take_new;
   logic        accept;
   logic        commit;

   // Pick the winning request first; only the winner's target is alignment-checked.
   always_comb begin
      raw_tgt = EXC_VECTOR;
      raw_pri = 2'd3;
      req_chk = 1'b0;
      if (exc_req) begin
         raw_tgt = EXC_VECTOR;
         raw_pri = 2'd3;
      end else if (eret_req) begin
         raw_tgt = epc;
         raw_pri = 2'd2;
         req_chk = 1'b1;
      end else if (br_taken) begin
         raw_tgt = br_target;
         raw_pri = 2'd1;
         req_chk = 1'b1;
      end else if (jmp_valid) begin
         raw_tgt = jmp_target;
         raw_pri = 2'd0;
         req_chk = 1'b1;
      end
      req_any  = exc_req | eret_req | br_taken | jmp_valid;
      misalign = req_any & req_chk & (raw_tgt[1:0] != 2'b00);
      req_tgt  = misalign ? EXC_VECTOR : raw_tgt;
      req_pri  = misalign ? 2'd3 : raw_pri;
      take_new = req_any & (req_pri >= pend_pri_q);
   end

   always_comb begin
      pc_next    = pc_cur + 32'd4;
      pc_we      = 1'b0;
      state_d    = state_q;
      pend_pc_d  = pend_pc_q;
      pend_pri_d = pend_pri_q;
      accept     = 1'b0;
      commit     = 1'b0;
      if (rst) begin
         pc_next = RESET_PC;
      end else if (state_q == ST_RUN) begin
         if (!stall) begin
            pc_we = 1'b1;
            if (req_any) begin
               pc_next = req_tgt;
               accept  = 1'b1;
               commit  = 1'b1;
            end
         end else if (req_any) begin
            pend_pc_d  = req_tgt;
            pend_pri_d = req_pri;
            state_d    = ST_HOLD;
            accept     = 1'b1;
         end
      end else begin
         if (stall) begin
            if (take_new) begin
               pend_pc_d  = req_tgt;
               pend_pri_d = req_pri;
               accept     = 1'b1;
            end
         end else begin
            pc_we   = 1'b1;
            pc_next = take_new ? req_tgt : pend_pc_q;
            accept  = take_new;
            commit  = 1'b1;
            state_d = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         pend_pc_q  <= '0;
         pend_pri_q <= '0;
         flush_if   <= 1'b0;
         addr_err   <= 1'b0;
         bad_addr   <= '0;
         redir_cnt  <= '0;
      end else begin
         state_q    <= state_d;
         pend_pc_q  <= pend_pc_d;
         pend_pri_q <= pend_pri_d;
         flush_if   <= commit;
         addr_err   <= accept & misalign;
         if (accept && misalign) begin
            bad_addr <= raw_tgt;
         end
         if (commit && (redir_cnt != {CNT_W{1'b1}})) begin
            redir_cnt <= redir_cnt + CNT_W'(1);
         end
      end
   end

   assign redirect_pending = (state_q == ST_HOLD);

endmodule
